// File: rtl/sdm_stream_ctrl.sv
// Sample scheduler and soft-mute controller feeding the 2nd-order
// sigma-delta modulator. PCM samples arrive over a valid/ready stream
// into a small FIFO. One sample is released every OSR clocks and scaled
// by a gain that ramps linearly on start/stop, so the PDM output does not
// pop. An empty FIFO at a sample tick while playing raises a sticky
// underrun flag.
module sdm_stream_ctrl #(
  parameter int OSR        = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int RAMP_STEP  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [15:0]                   s_data,
  input  logic                          clr_underrun,
  output logic [15:0]                   dac_in,
  output logic                          sample_tick,
  output logic                          active,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [CW-1:0] OSR_LAST   = CW'(OSR - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [LW-1:0] LVL_FULL   = LW'(FIFO_DEPTH);
  localparam logic [8:0]    GAIN_MAX   = 9'd256;
  localparam logic [8:0]    STEP       = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RUN       = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  // Registered state
  state_t             state;
  logic [CW-1:0]      osr_cnt;
  logic [8:0]         gain;
  logic signed [15:0] cur_sample;
  logic [15:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      count;

  // Next-state / datapath signals
  state_t             state_next;
  logic [8:0]         gain_next;
  logic [8:0]         gain_up;
  logic [8:0]         gain_dn;
  logic [9:0]         gain_sum;
  logic [CW-1:0]      osr_cnt_next;
  logic               tick_next;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_flush;
  logic               push;
  logic               pop;
  logic               underrun_set;
  logic               underrun_next;
  logic signed [15:0] cur_sample_next;
  logic signed [25:0] sample_ext;
  logic signed [25:0] gain_ext;
  logic signed [25:0] prod;
  logic [15:0]        dac_next;

  // FIFO status and stream handshake; ready never looks at a same-cycle pop
  always_comb begin
    fifo_full  = (count == LVL_FULL);
    fifo_empty = (count == {LW{1'b0}});
    s_ready    = (state != ST_IDLE) && !fifo_full;
    push       = s_valid && s_ready;
    pop        = sample_tick && !fifo_empty;
    active     = (state != ST_IDLE);
    fifo_level = count;
  end

  // Saturating gain step candidates for the ramp states
  always_comb begin
    gain_sum = {1'b0, gain} + {1'b0, STEP};
    if (gain_sum > {1'b0, GAIN_MAX}) begin
      gain_up = GAIN_MAX;
    end else begin
      gain_up = gain_sum[8:0];
    end
    if (gain > STEP) begin
      gain_dn = gain - STEP;
    end else begin
      gain_dn = 9'd0;
    end
  end

  // Play/mute FSM: next state and gain; en always wins over ramp completion
  always_comb begin
    state_next = state;
    gain_next  = gain;
    case (state)
      ST_IDLE: begin
        gain_next = 9'd0;
        if (en) begin
          state_next = ST_RAMP_UP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RAMP_UP: begin
        if (sample_tick) begin
          gain_next = gain_up;
        end else begin
          gain_next = gain;
        end
        if (!en) begin
          state_next = ST_RAMP_DOWN;
        end else if (sample_tick && (gain_up == GAIN_MAX)) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_RAMP_UP;
        end
      end
      ST_RUN: begin
        gain_next = GAIN_MAX;
        if (!en) begin
          state_next = ST_RAMP_DOWN;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RAMP_DOWN: begin
        if (sample_tick) begin
          gain_next = gain_dn;
        end else begin
          gain_next = gain;
        end
        if (en) begin
          state_next = ST_RAMP_UP;
        end else if (sample_tick && (gain_dn == 9'd0)) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RAMP_DOWN;
        end
      end
      default: begin
        state_next = ST_IDLE;
        gain_next  = 9'd0;
      end
    endcase
  end

  // Oversampling counter: parked at zero in IDLE, free-running 0..OSR-1 otherwise
  always_comb begin
    if ((state == ST_IDLE) || (state_next == ST_IDLE)) begin
      osr_cnt_next = {CW{1'b0}};
    end else if (osr_cnt == OSR_LAST) begin
      osr_cnt_next = {CW{1'b0}};
    end else begin
      osr_cnt_next = osr_cnt + CNT_ONE;
    end
    tick_next  = (state_next != ST_IDLE) && (osr_cnt_next == OSR_LAST);
    fifo_flush = (state == ST_IDLE) || (state_next == ST_IDLE);
  end

  // Tick-time sample fetch and sticky underrun (set beats clear)
  always_comb begin
    underrun_set = sample_tick && fifo_empty &&
                   ((state == ST_RAMP_UP) || (state == ST_RUN));
    if (underrun_set) begin
      underrun_next = 1'b1;
    end else if (clr_underrun) begin
      underrun_next = 1'b0;
    end else begin
      underrun_next = underrun;
    end
    if (state == ST_IDLE) begin
      cur_sample_next = 16'sd0;
    end else if (pop) begin
      cur_sample_next = mem[rd_ptr];
    end else begin
      cur_sample_next = cur_sample;
    end
  end

  // Gain scaling: Q8 gain, 256 is unity; dropping 8 LSBs floors toward -inf
  always_comb begin
    sample_ext = 26'(cur_sample);
    gain_ext   = $signed({17'd0, gain});
    prod       = sample_ext * gain_ext;
    if (state == ST_IDLE) begin
      dac_next = 16'd0;
    end else begin
      dac_next = 16'(prod >> 8);
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      osr_cnt     <= {CW{1'b0}};
      sample_tick <= 1'b0;
      gain        <= 9'd0;
      cur_sample  <= 16'sd0;
      dac_in      <= 16'd0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_next;
      osr_cnt     <= osr_cnt_next;
      sample_tick <= tick_next;
      gain        <= gain_next;
      cur_sample  <= cur_sample_next;
      dac_in      <= dac_next;
      underrun    <= underrun_next;
    end
  end

  // FIFO pointers and occupancy; leaving for IDLE discards queued samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {LW{1'b0}};
    end else if (fifo_flush) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {LW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push && !fifo_flush) begin
      mem[wr_ptr] <= s_data;
    end
  end

endmodule

// File: tb/tb_sdm_stream_ctrl.sv
// Directed bench for sdm_stream_ctrl with OSR=4, FIFO_DEPTH=4, RAMP_STEP=64.
// Expected dac_in values are hand computed as floor(sample*gain/256).
module tb_sdm_stream_ctrl;

  localparam int OSR        = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int RAMP_STEP  = 64;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               s_valid;
  logic               s_ready;
  logic [15:0]        s_data;
  logic               clr_underrun;
  logic signed [15:0] dac_in;
  logic               sample_tick;
  logic               active;
  logic               underrun;
  logic [2:0]         fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_tick_cyc = 0;
  bit have_last = 1'b0;
  int last_dac  = 0;

  sdm_stream_ctrl #(
    .OSR        (OSR),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RAMP_STEP  (RAMP_STEP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .clr_underrun (clr_underrun),
    .dac_in       (dac_in),
    .sample_tick  (sample_tick),
    .active       (active),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Free-running cycle counter for tick spacing
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net against a stuck run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 40; i++) begin
      if (!done) begin
        done = s_ready;
        step();
      end
    end
    s_valid = 1'b0;
    chk_eq("push_accepted", int'(done), 1);
  endtask

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!seen) begin
        if (sample_tick) seen = 1'b1;
        else step();
      end
    end
    chk_eq({tag, "_tick"}, int'(seen), 1);
    if (have_last) chk_eq({tag, "_period"}, cyc - last_tick_cyc, OSR);
    last_tick_cyc = cyc;
    have_last     = 1'b1;
  endtask

  task automatic tick_chk(input string tag, input int exp);
    wait_tick(tag);
    step();
    chk_eq({tag, "_hold"}, int'(dac_in), last_dac);
    step();
    chk_eq({tag, "_dac"}, int'(dac_in), exp);
    last_dac = exp;
  endtask

  initial begin
    bit any_tick, any_ready, any_dac, any_active;
    rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 16'h0000; clr_underrun = 1'b0;
    repeat (3) step();

    // Reset state
    chk_eq("rst_dac", int'(dac_in), 0);
    chk_eq("rst_active", int'(active), 0);
    chk_eq("rst_tick", int'(sample_tick), 0);
    chk_eq("rst_underrun", int'(underrun), 0);
    chk_eq("rst_level", int'(fifo_level), 0);
    chk_eq("rst_ready", int'(s_ready), 0);

    // IDLE with en=0 and s_valid=1 for 100 cycles
    rst_n = 1'b1; s_valid = 1'b1; s_data = 16'h1234;
    any_tick = 1'b0; any_ready = 1'b0; any_dac = 1'b0; any_active = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      any_tick   |= sample_tick;
      any_ready  |= s_ready;
      any_dac    |= (dac_in != 16'sd0);
      any_active |= active;
    end
    s_valid = 1'b0;
    chk_eq("idle_tick", int'(any_tick), 0);
    chk_eq("idle_ready", int'(any_ready), 0);
    chk_eq("idle_dac", int'(any_dac), 0);
    chk_eq("idle_active", int'(any_active), 0);
    chk_eq("idle_level", int'(fifo_level), 0);

    // Ramp up over 4 ticks with 0x4000 samples
    have_last = 1'b0; last_dac = 0;
    en = 1'b1;
    step();
    chk_eq("ru_active", int'(active), 1);
    push(16'h4000); push(16'h4000); push(16'h4000);
    tick_chk("ru1", 4096);
    push(16'h4000);
    tick_chk("ru2", 8192);
    push(16'h4000);
    tick_chk("ru3", 12288);
    tick_chk("ru4", 16384);
    tick_chk("ru5", 16384);
    chk_eq("ru_underrun", int'(underrun), 0);

    // Unity-gain passthrough of extreme values
    push(16'h8000);
    tick_chk("pt_min", -32768);
    push(16'h7FFF);
    tick_chk("pt_max", 32767);
    push(16'hFFFF);
    tick_chk("pt_neg1", -1);

    // Underrun: set on empty tick, set beats clear, later clear works
    tick_chk("ur_hold", -1);
    chk_eq("ur_set", int'(underrun), 1);
    wait_tick("ur_clr");
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk_eq("ur_set_prio", int'(underrun), 1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    chk_eq("ur_clear", int'(underrun), 0);
    chk_eq("ur_dac_hold", int'(dac_in), -1);

    // Full FIFO held across a tick; next tick period check restarts here
    have_last = 1'b0;
    push(16'h0100); push(16'h0200); push(16'h0300); push(16'h0400); push(16'h0500);
    chk_eq("full_level", int'(fifo_level), 4);
    chk_eq("full_ready", int'(s_ready), 0);
    s_valid = 1'b1; s_data = 16'h0600;
    wait_tick("full");
    chk_eq("full_tick_ready", int'(s_ready), 0);
    step();
    chk_eq("pop_level", int'(fifo_level), 3);
    chk_eq("pop_ready", int'(s_ready), 1);
    chk_eq("ord_a", int'(dac_in), 256);
    step();
    s_valid = 1'b0;
    chk_eq("refill_level", int'(fifo_level), 4);
    chk_eq("ord_b", int'(dac_in), 512);
    chk_eq("full_underrun", int'(underrun), 0);
    last_dac = 512;
    tick_chk("ord_c", 768);
    tick_chk("ord_d", 1024);
    tick_chk("ord_e", 1280);
    tick_chk("ord_f", 1536);

    // Ramp down to 128, then reverse back up to RUN
    en = 1'b0;
    push(16'h0100); push(16'h8000);
    tick_chk("rd192", 192);
    tick_chk("rd128", -16384);
    en = 1'b1;
    push(16'h0100);
    tick_chk("rv192", 192);
    push(16'h0100);
    tick_chk("rv256", 256);
    chk_eq("rv_underrun", int'(underrun), 0);

    // Full ramp down to IDLE with flush
    en = 1'b0;
    push(16'h0100); push(16'hFFFF);
    tick_chk("fd192", 192);
    push(16'h0100);
    tick_chk("fd128", -1);
    push(16'h0100); push(16'h1234);
    tick_chk("fd64", 64);
    push(16'h2222);
    wait_tick("fd0");
    step();
    chk_eq("fd0_level", int'(fifo_level), 0);
    chk_eq("fd0_active", int'(active), 0);
    chk_eq("fd0_ready", int'(s_ready), 0);
    chk_eq("fd0_hold", int'(dac_in), 64);
    step();
    chk_eq("fd0_dac", int'(dac_in), 0);
    any_tick = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any_tick |= sample_tick;
    end
    chk_eq("fd0_no_tick", int'(any_tick), 0);
    chk_eq("fd0_underrun", int'(underrun), 0);

    // Restart with empty FIFO (underrun in RAMP_UP), then reset mid-run
    have_last = 1'b0;
    en = 1'b1;
    wait_tick("rs_first");
    step();
    chk_eq("rs_underrun", int'(underrun), 1);
    push(16'h1111);
    rst_n = 1'b0;
    step();
    chk_eq("rs_level", int'(fifo_level), 0);
    chk_eq("rs_active", int'(active), 0);
    chk_eq("rs_underrun_clr", int'(underrun), 0);
    chk_eq("rs_dac", int'(dac_in), 0);
    chk_eq("rs_tick", int'(sample_tick), 0);
    chk_eq("rs_ready", int'(s_ready), 0);
    rst_n = 1'b1; en = 1'b0;
    step();
    chk_eq("rs_idle", int'(active), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
